regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the next-generation RISC-V core.
- Configurable data width, address width, and read/write port counts, so one instance serves dual-issue pipelines.
- Adds a per-register scoreboard (pending-write bits) that issue logic uses to detect RAW hazards.
- Adds a sequential post-reset clear engine that zeroes every architectural register.
- Sits between decode/issue (read and scoreboard ports) and writeback (write ports).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports
NUM_WR, 2, number of write ports

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
ready  out  1  1 = clear finished, file usable
we  in  NUM_WR  write enable per write port
waddr  in  NUM_WR*ADDR_W  write addresses, port j at bits [j*ADDR_W +: ADDR_W]
wdata  in  NUM_WR*DATA_W  write data, port j at bits [j*DATA_W +: DATA_W]
re  in  NUM_RD  read enable per read port
raddr  in  NUM_RD*ADDR_W  read addresses, packed the same way as waddr
rdata  out  NUM_RD*DATA_W  read data, combinational
rd_busy  out  NUM_RD  scoreboard bit for raddr[i]
sb_set  in  1  mark sb_addr as pending (instruction issued)
sb_addr  in  ADDR_W  destination register being issued

Behaviour:
- Reset and clear FSM:
  - States: CLEAR, RUN.
  - rst=1 at an edge: state<=CLEAR, clr_idx<=1, all busy bits<=0, ready<=0.
  - In CLEAR, each cycle regs[clr_idx]<=0 and clr_idx increments.
  - The edge that writes the last index 2**ADDR_W-1 moves the state to RUN and sets ready<=1.
  - Clear takes 2**ADDR_W-1 cycles after rst deasserts; 31 cycles at the default.
  - rst asserted mid-clear restarts the clear from index 1.
  - No other transition into CLEAR.
- While in CLEAR (ready=0):
  - we and sb_set are ignored.
  - rdata=0 and rd_busy=0 on every port.
- x0:
  - Never written.
  - Always reads 0.
  - Never busy; sb_set with sb_addr=0 is ignored.
- Writes (RUN only):
  - For each j with we[j]=1 and waddr[j]!=0, regs[waddr[j]]<=wdata[j] at the edge.
  - When several ports target the same address, the highest-index port wins.
- Reads (combinational, per port i):
  - re[i]=0 or raddr[i]=0 or ready=0 -> rdata[i]=0.
  - Otherwise, if a write port j has we[j] and waddr[j]==raddr[i], forward wdata of the highest such j.
  - Otherwise rdata[i]=regs[raddr[i]].
- Scoreboard:
  - busy[sb_addr]<=1 when sb_set=1 in RUN.
  - busy[waddr[j]]<=0 for each active write port j.
  - If a set and a clear hit the same address in the same cycle, the set wins: the busy bit is set again because a newer producer was issued.
  - rd_busy[i] = busy[raddr[i]], forced to 0 when any write port hits raddr[i] this cycle (forwarding covers it), when raddr[i]=0, or when re[i]=0.
- Read latency: 0 cycles. Write and scoreboard latency: 1 edge.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: same-cycle write-to-read forwarding of rdata, and same-cycle suppression of rd_busy, both as described above.
- Undefined:
  - rdata is the array value only, i.e. the pre-write value during a same-cycle write.
  - rd_busy reflects the busy register only; it drops one cycle after the write edge.
  - All other behaviour is unchanged.

Test Plan:
1. Clear sequence: pulse rst 1 cycle -> ready=0 for exactly 31 cycles, then ready=1; read x1..x31 -> all 0.
2. Clear restart and CLEAR gating: rst again at cycle 10 of the clear -> 31 more cycles before ready=1; we=1 during the clear -> no effect.
3. Write/read with x0: port0 writes x5=0xDEADBEEF, next cycle read port1 raddr=5 -> 0xDEADBEEF; write x0=0x1234 -> x0 reads 0, sb_set with sb_addr=0 -> rd_busy stays 0.
4. Same-cycle port conflict: port0 writes x7=0x11 and port1 writes x7=0x22 in the same cycle -> next cycle x7 reads 0x22.
5. Forwarding (REGFILE_BYPASS_EN defined): write x3=0xAA with x3 previously 0x55, read x3 in the same cycle -> rdata=0xAA, rd_busy=0. Undefined -> rdata=0x55, rd_busy=1 if x3 was busy.
6. Scoreboard: sb_set x9 -> next cycle rd_busy=1 for raddr 9; a write to x9 together with sb_set x9 in the same cycle -> busy remains 1; a later write to x9 alone -> busy 0 the next cycle.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file with a per-register
// scoreboard and a sequential post-reset clear engine.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> same-cycle write-to-read forwarding of rdata and same-cycle
//                suppression of rd_busy.
//   undefined -> rdata is the array value only (pre-write value during a
//                same-cycle write); rd_busy is the busy register only.
//
// Ports:
//   clk      in   clock, all state updates on rising edge
//   rst      in   synchronous active-high reset, starts the clear engine
//   ready    out  1 = clear finished, file usable
//   we       in   [NUM_WR]         write enable per write port
//   waddr    in   [NUM_WR*ADDR_W]  write addresses, port j at [j*ADDR_W +: ADDR_W]
//   wdata    in   [NUM_WR*DATA_W]  write data, port j at [j*DATA_W +: DATA_W]
//   re       in   [NUM_RD]         read enable per read port
//   raddr    in   [NUM_RD*ADDR_W]  read addresses, packed like waddr
//   rdata    out  [NUM_RD*DATA_W]  combinational read data
//   rd_busy  out  [NUM_RD]         scoreboard (pending-write) bit for raddr[i]
//   sb_set   in   mark sb_addr as pending
//   sb_addr  in   [ADDR_W]         destination register being issued
module regfile_mp #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned NUM_WR = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       ready,
    input  logic [NUM_WR-1:0]          we,
    input  logic [NUM_WR*ADDR_W-1:0]   waddr,
    input  logic [NUM_WR*DATA_W-1:0]   wdata,
    input  logic [NUM_RD-1:0]          re,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       sb_set,
    input  logic [ADDR_W-1:0]          sb_addr
);

    localparam int unsigned       DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        StClear,
        StRun
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;

    // Unpacked views of the packed port buses.
    logic [ADDR_W-1:0] waddr_a [NUM_WR];
    logic [DATA_W-1:0] wdata_a [NUM_WR];
    logic [ADDR_W-1:0] raddr_a [NUM_RD];

    always_comb begin
        for (int j = 0; j < NUM_WR; j++) begin
            waddr_a[j] = waddr[j*ADDR_W +: ADDR_W];
            wdata_a[j] = wdata[j*DATA_W +: DATA_W];
        end
        for (int i = 0; i < NUM_RD; i++) begin
            raddr_a[i] = raddr[i*ADDR_W +: ADDR_W];
        end
    end

    // ------------------------------------------------------------------
    // Same-cycle forwarding: for each read port, find the highest-index
    // write port targeting the same address.
    // ------------------------------------------------------------------
    logic [NUM_RD-1:0] fwd_hit;
    logic [DATA_W-1:0] fwd_data [NUM_RD];

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            fwd_hit[i]  = 1'b0;
            fwd_data[i] = '0;
            // Ascending scan so the highest matching port overrides.
            for (int j = 0; j < NUM_WR; j++) begin
                if (we[j] && (waddr_a[j] == raddr_a[i])) begin
                    fwd_hit[i]  = 1'b1;
                    fwd_data[i] = wdata_a[j];
                end
            end
        end
    end
`else
    always_comb begin
        fwd_hit = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            fwd_data[i] = '0;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Read ports: zero while clearing, for x0, or when not enabled.
    // ------------------------------------------------------------------
    always_comb begin
        rdata   = '0;
        rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (ready_q && re[i] && (raddr_a[i] != '0)) begin
                rdata[i*DATA_W +: DATA_W] = fwd_hit[i] ? fwd_data[i] : regs_q[raddr_a[i]];
                // A write landing this cycle covers the hazard via forwarding.
                rd_busy[i] = busy_q[raddr_a[i]] & ~fwd_hit[i];
            end
        end
    end

    assign ready = ready_q;

    // ------------------------------------------------------------------
    // Next-state: clear engine, writes and scoreboard.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        ready_d   = ready_q;
        regs_d    = regs_q;
        busy_d    = busy_q;

        case (state_q)
            StClear: begin
                // Writes and scoreboard sets are ignored until the sweep ends.
                regs_d[clr_idx_q] = '0;
                clr_idx_d         = clr_idx_q + 1'b1;
                if (clr_idx_q == LAST_IDX) begin
                    state_d = StRun;
                    ready_d = 1'b1;
                end
            end
            StRun: begin
                // Ascending port order: the highest-index port wins a conflict.
                for (int j = 0; j < NUM_WR; j++) begin
                    if (we[j] && (waddr_a[j] != '0)) begin
                        regs_d[waddr_a[j]] = wdata_a[j];
                    end
                end
                for (int j = 0; j < NUM_WR; j++) begin
                    if (we[j]) begin
                        busy_d[waddr_a[j]] = 1'b0;
                    end
                end
                // Applied after the clears: a newly issued producer keeps the
                // register pending even if an older write retires now.
                if (sb_set) begin
                    busy_d[sb_addr] = 1'b1;
                end
            end
            default: begin
                state_d = StClear;
            end
        endcase

        // x0 is hard-wired: never holds data, never pending.
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    // ------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StClear;
            clr_idx_q <= FIRST_IDX;
            ready_q   <= 1'b0;
            busy_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    // Array contents are not reset directly; the clear engine zeroes them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 2;
    localparam int unsigned NW = 2;

    logic            clk;
    logic            rst;
    logic            ready;
    logic [NW-1:0]   we;
    logic [NW*AW-1:0] waddr;
    logic [NW*DW-1:0] wdata;
    logic [NR-1:0]   re;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]   rd_busy;
    logic            sb_set;
    logic [AW-1:0]   sb_addr;

    int n_cmp;
    int n_err;
    int cnt;

    regfile_mp #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .NUM_RD(NR),
        .NUM_WR(NW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ready   (ready),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .re      (re),
        .raddr   (raddr),
        .rdata   (rdata),
        .rd_busy (rd_busy),
        .sb_set  (sb_set),
        .sb_addr (sb_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we      = '0;
        waddr   = '0;
        wdata   = '0;
        re      = '0;
        raddr   = '0;
        sb_set  = 1'b0;
        sb_addr = '0;
    endtask

    // Count edges until ready rises, bounded.
    task automatic wait_ready(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!ready && n < 100);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        idle_inputs();

        // ---- 1: clear sequence ----
        step();
        step();
        chk("reset_ready", ready, 0);
        rst = 1'b0;
        re  = 2'b11;
        raddr = {5'd2, 5'd1};
        cnt = 0;
        do begin
            step();
            cnt++;
            if (cnt == 5) begin
                chk("clear_rdata", rdata, 0);
                chk("clear_busy", rd_busy, 0);
            end
        end while (!ready && cnt < 100);
        chk("clear_len", cnt, 31);
        re = 2'b01;
        for (int a = 1; a < 32; a++) begin
            raddr[AW-1:0] = AW'(a);
            #1;
            chk($sformatf("zero_x%0d", a), rdata[DW-1:0], 0);
        end
        idle_inputs();

        // ---- 2: clear restart, writes/sb_set ignored during clear ----
        rst = 1'b1;
        step();
        rst = 1'b0;
        we             = 2'b01;
        waddr[AW-1:0]  = 5'd4;
        wdata[DW-1:0]  = 32'h0000_0BAD;
        sb_set         = 1'b1;
        sb_addr        = 5'd4;
        repeat (10) step();
        chk("restart_notready", ready, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_ready(cnt);
        chk("restart_len", cnt, 31);
        idle_inputs();
        re = 2'b01;
        raddr[AW-1:0] = 5'd4;
        #1;
        chk("gated_write", rdata[DW-1:0], 0);
        chk("gated_sbset", rd_busy[0], 0);
        idle_inputs();

        // ---- 3: write/read, x0 ----
        we            = 2'b01;
        waddr[AW-1:0] = 5'd5;
        wdata[DW-1:0] = 32'hDEAD_BEEF;
        step();
        idle_inputs();
        re                = 2'b10;
        raddr[2*AW-1:AW]  = 5'd5;
        #1;
        chk("read_x5_p1", rdata[2*DW-1:DW], 32'hDEAD_BEEF);
        chk("p0_disabled", rdata[DW-1:0], 0);
        idle_inputs();
        we            = 2'b01;
        waddr[AW-1:0] = 5'd0;
        wdata[DW-1:0] = 32'h0000_1234;
        step();
        idle_inputs();
        sb_set  = 1'b1;
        sb_addr = 5'd0;
        step();
        idle_inputs();
        re            = 2'b01;
        raddr[AW-1:0] = 5'd0;
        #1;
        chk("x0_read", rdata[DW-1:0], 0);
        chk("x0_busy", rd_busy[0], 0);
        idle_inputs();

        // ---- 4: same-cycle port conflict on x7 ----
        we    = 2'b11;
        waddr = {5'd7, 5'd7};
        wdata = {32'h0000_0022, 32'h0000_0011};
        re    = 2'b01;
        raddr[AW-1:0] = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("conflict_fwd", rdata[DW-1:0], 32'h0000_0022);
`else
        chk("conflict_nofwd", rdata[DW-1:0], 0);
`endif
        step();
        we = '0;
        #1;
        chk("conflict_x7", rdata[DW-1:0], 32'h0000_0022);
        idle_inputs();

        // ---- 5: forwarding vs. array value, x3 busy ----
        we            = 2'b01;
        waddr[AW-1:0] = 5'd3;
        wdata[DW-1:0] = 32'h0000_0055;
        step();
        idle_inputs();
        sb_set  = 1'b1;
        sb_addr = 5'd3;
        step();
        idle_inputs();
        re            = 2'b01;
        raddr[AW-1:0] = 5'd3;
        #1;
        chk("x3_pending", rd_busy[0], 1);
        we                = 2'b10;
        waddr[2*AW-1:AW]  = 5'd3;
        wdata[2*DW-1:DW]  = 32'h0000_00AA;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("fwd_rdata", rdata[DW-1:0], 32'h0000_00AA);
        chk("fwd_busy", rd_busy[0], 0);
`else
        chk("nofwd_rdata", rdata[DW-1:0], 32'h0000_0055);
        chk("nofwd_busy", rd_busy[0], 1);
`endif
        step();
        we = '0;
        #1;
        chk("x3_after", rdata[DW-1:0], 32'h0000_00AA);
        chk("x3_busy_after", rd_busy[0], 0);
        idle_inputs();

        // ---- 6: scoreboard set/clear priority on x9 ----
        sb_set  = 1'b1;
        sb_addr = 5'd9;
        step();
        idle_inputs();
        re               = 2'b10;
        raddr[2*AW-1:AW] = 5'd9;
        #1;
        chk("sb_x9_set", rd_busy[1], 1);
        re = 2'b00;
        #1;
        chk("sb_re_off", rd_busy[1], 0);
        re            = 2'b10;
        we            = 2'b01;
        waddr[AW-1:0] = 5'd9;
        wdata[DW-1:0] = 32'h0000_0099;
        sb_set        = 1'b1;
        sb_addr       = 5'd9;
        step();
        we     = '0;
        sb_set = 1'b0;
        #1;
        chk("sb_set_wins", rd_busy[1], 1);
        chk("x9_data", rdata[2*DW-1:DW], 32'h0000_0099);
        we            = 2'b01;
        waddr[AW-1:0] = 5'd9;
        wdata[DW-1:0] = 32'h0000_009A;
        step();
        we = '0;
        #1;
        chk("sb_x9_clear", rd_busy[1], 0);
        chk("x9_data2", rdata[2*DW-1:DW], 32'h0000_009A);
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
